keypad_scan_ctrl: RTL and testbench

Row-scanning, debouncing front-end controller for the 4x3 lock keypad. It drives the keypad rows, samples the columns, and debounces press and release. Each debounced key is encoded into the 4-bit lock code and delivered to the lock decider as `Code_1`, a one-clock `Valid_1` strobe and an `S_Row` key-held level. It sits between the keypad pins and the decider; the decider never sees raw key activity.

---
 rtl/keypad_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Row-scanning, debouncing front end for the 4x3 lock keypad. One row is
// driven low at a time; the active-low columns are double-flop synchronised
// and sampled once per scan tick. A key is accepted after DEBOUNCE_CNT
// identical samples, encoded into the 4-bit lock code and handed to the lock
// decider. Release is debounced the same way before scanning resumes.
//
// Ports:
//   clk      in  1  system clock, rising edge
//   reset_1  in  1  asynchronous active-low reset
//   col      in  3  keypad columns, active-low, asynchronous to clk
//   row      out 4  row drive, one-cold
//   Code_1   out 4  last accepted key code
//   Valid_1  out 1  one-clock strobe per accepted press
//   S_Row    out 1  high while the accepted key is held
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
   parameter int SCAN_DIV     = 4,
   parameter int DEBOUNCE_CNT = 3
) (
   input  logic       clk,
   input  logic       reset_1,
   input  logic [2:0] col,
   output logic [3:0] row,
   output logic [3:0] Code_1,
   output logic       Valid_1,
   output logic       S_Row
);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_PRESS_DB = 2'd1,
      ST_HELD     = 2'd2,
      ST_REL_DB   = 2'd3
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  DB_DONE  = 8'(DEBOUNCE_CNT);

   state_t      state_q, state_d;
   logic [2:0]  col_meta_q;
   logic [2:0]  sc_q;
   logic [15:0] div_q;
   logic [1:0]  row_idx_q, row_idx_d;
   logic [2:0]  pat_q, pat_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  code_q, code_d;
   logic        valid_q, valid_d;

   logic        tick;
   logic        sc_idle;
   logic        sc_single;

   assign tick      = (div_q == DIV_LAST);
   assign sc_idle   = (sc_q == 3'b111);
   assign sc_single = (sc_q == 3'b110) || (sc_q == 3'b101) || (sc_q == 3'b011);

   // Column index of a single-low pattern.
   function automatic logic [1:0] col_index(input logic [2:0] pat);
      case (pat)
         3'b110:  col_index = 2'd0;
         3'b101:  col_index = 2'd1;
         3'b011:  col_index = 2'd2;
         default: col_index = 2'd0;
      endcase
   endfunction

   // Lock code for (row index, column index).
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'b00_00: key_code = 4'b0001;
         4'b00_01: key_code = 4'b0010;
         4'b00_10: key_code = 4'b0011;
         4'b01_00: key_code = 4'b0100;
         4'b01_01: key_code = 4'b0101;
         4'b01_10: key_code = 4'b0110;
         4'b10_00: key_code = 4'b0111;
         4'b10_01: key_code = 4'b1000;
         4'b10_10: key_code = 4'b1001;
         4'b11_00: key_code = 4'b1011;
         4'b11_01: key_code = 4'b0000;
         4'b11_10: key_code = 4'b1010;
         default:  key_code = 4'b0000;
      endcase
   endfunction

   // State register, synchroniser and prescaler.
   always_ff @(posedge clk or negedge reset_1) begin
      if (!reset_1) begin
         state_q    <= ST_SCAN;
         col_meta_q <= 3'b111;
         sc_q       <= 3'b111;
         div_q      <= '0;
         row_idx_q  <= '0;
         pat_q      <= 3'b111;
         cnt_q      <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_meta_q <= col;
         sc_q       <= col_meta_q;
         div_q      <= tick ? 16'd0 : div_q + 16'd1;
         row_idx_q  <= row_idx_d;
         pat_q      <= pat_d;
         cnt_q      <= cnt_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
      end
   end

   // Next-state logic. The row index is frozen outside SCAN, so it doubles
   // as the latched row of the key being debounced or held.
   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      pat_d     = pat_q;
      cnt_d     = cnt_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (sc_single) begin
                  pat_d = sc_q;
                  cnt_d = 8'd1;
                  if (cnt_d == DB_DONE) begin
                     state_d = ST_HELD;
                     code_d  = key_code(row_idx_q, col_index(sc_q));
                     valid_d = 1'b1;
                  end else begin
                     state_d = ST_PRESS_DB;
                  end
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
            ST_PRESS_DB: begin
               if (sc_q == pat_q) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_d == DB_DONE) begin
                     state_d = ST_HELD;
                     code_d  = key_code(row_idx_q, col_index(pat_q));
                     valid_d = 1'b1;
                  end
               end else begin
                  state_d   = ST_SCAN;
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
            ST_HELD: begin
               // Anything but all-released (second key, other column) is ignored.
               if (sc_idle) begin
                  cnt_d = 8'd1;
                  if (cnt_d == DB_DONE) begin
                     state_d   = ST_SCAN;
                     row_idx_d = row_idx_q + 2'd1;
                  end else begin
                     state_d = ST_REL_DB;
                  end
               end
            end
            ST_REL_DB: begin
               if (sc_idle) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_d == DB_DONE) begin
                     state_d   = ST_SCAN;
                     row_idx_d = row_idx_q + 2'd1;
                  end
               end else begin
                  state_d = ST_HELD;
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end
   end

   // Outputs.
   always_comb begin
      row     = ~(4'b0001 << row_idx_q);
      Code_1  = code_q;
      Valid_1 = valid_q;
      S_Row   = (state_q == ST_HELD) || (state_q == ST_REL_DB);
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

   logic       clk;
   logic       reset_1;
   logic [2:0] col;
   logic [3:0] row;
   logic [3:0] Code_1;
   logic       Valid_1;
   logic       S_Row;

   // Keypad model: bit r*3+c set = key at (row r, col c) is pressed.
   logic [11:0] keys;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] exp_q[$];
   logic       prev_valid = 1'b0;
   int         bad_row = 0;

   keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk(clk), .reset_1(reset_1), .col(col), .row(row),
      .Code_1(Code_1), .Valid_1(Valid_1), .S_Row(S_Row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      col = 3'b111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (keys[r*3+c] && !row[r]) col[c] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else
         $display("ok   %s: %0h", name, act);
   endtask

   task automatic check_range(input string name, input int val, input int lo, input int hi);
      n_checks++;
      if (val < lo || val > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
      end else
         $display("ok   %s: %0d", name, val);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int max, output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (!Valid_1 && lat < max);
      check({name, "_pulse_seen"}, Valid_1, 1'b1);
   endtask

   task automatic wait_fall(input string name, input int max, output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (S_Row && lat < max);
      check({name, "_srow_fall"}, S_Row, 1'b0);
   endtask

   // Returns just after the edge on which row0 becomes active.
   task automatic wait_row0();
      int n;
      n = 0;
      while (row == 4'b1110 && n < 40) begin step(); n++; end
      while (row != 4'b1110 && n < 40) begin step(); n++; end
      check("wait_row0", row, 4'b1110);
   endtask

   // Scoreboard monitor: one popped expectation per Valid_1 pulse.
   always @(negedge clk) begin
      if (reset_1) begin
         if ($countones(~row) != 1) bad_row++;
         if (Valid_1) begin
            check("valid_single_cycle", prev_valid, 1'b0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_valid: Code_1=%b, no pulse expected", Code_1);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               check("valid_code", Code_1, e);
            end
         end
         prev_valid = Valid_1;
      end else
         prev_valid = 1'b0;
   end

   int lat;
   int changes;
   logic flag;
   logic [3:0] prev_row;
   logic [3:0] idle_seq [4];
   int seq_key [3];
   logic [3:0] seq_code [3];

   initial begin
      idle_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      seq_key  = '{11, 9, 10};
      seq_code = '{4'b1010, 4'b1011, 4'b0000};
      keys    = '0;
      reset_1 = 1'b0;
      repeat (3) step();
      check("rst_row", row, 4'b1110);
      check("rst_code", Code_1, 4'b0000);
      check("rst_valid", Valid_1, 1'b0);
      check("rst_srow", S_Row, 1'b0);
      @(negedge clk) reset_1 = 1'b1;

      // Idle scan: rotation every 4 clocks, first change 4 edges after release.
      prev_row = row;
      flag = 1'b0;
      for (int k = 0; k < 8; k++) begin
         lat = 0;
         do begin
            step();
            lat++;
            if (Valid_1 || S_Row) flag = 1'b1;
         end while (row == prev_row && lat < 10);
         check("idle_row_seq", row, idle_seq[k % 4]);
         check("idle_row_dwell", lat, 4);
         prev_row = row;
      end
      check("idle_no_activity", flag, 1'b0);
      check("idle_code", Code_1, 4'b0000);

      // Press '5', hold 100 clocks, release.
      exp_q.push_back(4'b0101);
      keys[4] = 1'b1;
      wait_valid("key5", 40, lat);
      check_range("key5_latency", lat, 11, 30);
      check("key5_srow_at_pulse", S_Row, 1'b1);
      flag = 1'b0;
      repeat (100) begin step(); if (!S_Row) flag = 1'b1; end
      check("key5_srow_held", flag, 1'b0);
      keys = '0;
      wait_fall("key5", 20, lat);
      check_range("key5_release_latency", lat, 11, 14);
      check("key5_code_holds", Code_1, 4'b0101);
      repeat (10) step();

      // '#', '*', '0' in sequence.
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(seq_code[i]);
         keys[seq_key[i]] = 1'b1;
         wait_valid("seq", 40, lat);
         repeat (20) step();
         keys = '0;
         wait_fall("seq", 20, lat);
         repeat (8) step();
      end

      // Bounce on '2': one tick of contact, one tick open, then a firm hold.
      wait_row0();
      keys[1] = 1'b1;
      repeat (4) step();
      check("bounce_row_frozen", row, 4'b1110);
      keys = '0;
      repeat (4) step();
      check("bounce_abort_advance", row, 4'b1101);
      exp_q.push_back(4'b0010);
      keys[1] = 1'b1;
      wait_valid("key2", 40, lat);
      check("key2_code", Code_1, 4'b0010);
      repeat (12) step();
      keys = '0;
      wait_fall("key2", 20, lat);
      repeat (8) step();

      // Two keys in row0: invalid pattern, scanning continues.
      keys[0] = 1'b1;
      keys[1] = 1'b1;
      changes = 0;
      prev_row = row;
      repeat (60) begin
         step();
         if (row != prev_row) changes++;
         prev_row = row;
      end
      check_range("twokey_scan_continues", changes, 14, 15);
      keys = '0;
      repeat (8) step();

      // Hold '7', add '9': no second pulse, S_Row stays high.
      exp_q.push_back(4'b0111);
      keys[6] = 1'b1;
      wait_valid("key7", 40, lat);
      keys[8] = 1'b1;
      flag = 1'b0;
      repeat (50) begin step(); if (!S_Row) flag = 1'b1; end
      check("key7_9_srow_held", flag, 1'b0);
      keys = '0;
      wait_fall("key7", 20, lat);
      repeat (8) step();

      // Reset during PRESS_DB on '1'.
      wait_row0();
      keys[0] = 1'b1;
      repeat (6) step();
      #2 reset_1 = 1'b0;
      #1;
      check("rstdb_row", row, 4'b1110);
      check("rstdb_srow", S_Row, 1'b0);
      check("rstdb_code", Code_1, 4'b0000);
      repeat (2) step();
      @(negedge clk) reset_1 = 1'b1;
      // Fresh press: sc valid after edge 2, detecting tick at edge 4, accept at edge 12.
      exp_q.push_back(4'b0001);
      wait_valid("key1_after_rst", 40, lat);
      check("key1_after_rst_latency", lat, 12);

      // Reset during HELD.
      repeat (10) step();
      check("held_before_rst", S_Row, 1'b1);
      #2 reset_1 = 1'b0;
      #1;
      check("rsthold_row", row, 4'b1110);
      check("rsthold_srow", S_Row, 1'b0);
      check("rsthold_code", Code_1, 4'b0000);
      keys = '0;
      repeat (2) step();
      @(negedge clk) reset_1 = 1'b1;
      repeat (40) step();
      exp_q.push_back(4'b1000);
      keys[7] = 1'b1;
      wait_valid("key8", 40, lat);
      check("key8_code", Code_1, 4'b1000);
      repeat (10) step();
      keys = '0;
      wait_fall("key8", 20, lat);
      repeat (10) step();

      check("row_one_cold", bad_row, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
